// File: rtl/issue_queue.sv
// Circular-buffer issue queue: up to 4 pushes and 2 pops per cycle, with a 2-entry head window.
// Optional IQ_PERF_COUNTER_EN adds iq_full_cycles (cycles spent full while decode keeps pushing).
package issue_queue_pkg;
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [9:0] imm;
  } ISSUE_QUEUE_ELEMENT;
endpackage

module iq_wr_lane #(
  parameter int AW   = 3,
  parameter int LANE = 0
) (
  input  logic [AW-1:0] tail,
  input  logic [AW:0]   push_acc,
  output logic          we,
  output logic [AW-1:0] idx
);
  assign we  = push_acc > (AW+1)'(LANE);
  assign idx = tail + AW'(LANE);
endmodule

module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  ISSUE_QUEUE_ELEMENT [3:0] issue_queue_element,
  input  logic [2:0]               issue_queue_push_number,
  output logic [2:0]               iq_size_left,
  input  logic                     flush,
  output ISSUE_QUEUE_ELEMENT [1:0] head_element,
  output logic [1:0]               head_valid,
  input  logic [1:0]               issue_pop_number,
  output logic                     push_overflow,
  output logic                     pop_underflow
`ifdef IQ_PERF_COUNTER_EN
  ,
  output logic [31:0]              iq_full_cycles
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [AW-1:0] head, tail;
  logic [AW:0]   count, free, push_req, pop_req, push_acc, pop_acc;
  logic [3:0]    we;
  logic [3:0][AW-1:0] widx;
  ISSUE_QUEUE_ELEMENT mem [DEPTH];

  // Push requests above 4 are clamped to the 4 available decode slots.
  assign free     = DEPTH_W - count;
  assign push_req = (AW+1)'(issue_queue_push_number > 3'd4 ? 3'd4 : issue_queue_push_number);
  assign pop_req  = (AW+1)'(issue_pop_number);
  assign push_acc = (push_req > free)  ? free  : push_req;
  assign pop_acc  = (pop_req  > count) ? count : pop_req;

  assign iq_size_left  = (free >= (AW+1)'(4)) ? 3'd4 : free[2:0];
  assign head_valid    = {count >= (AW+1)'(2), count >= (AW+1)'(1)};
  assign push_overflow = !rst && !flush && (push_req > free);
  assign pop_underflow = !rst && !flush && (pop_req > count);

  assign head_element[0] = mem[head];
  assign head_element[1] = mem[head + AW'(1)];

  for (genvar k = 0; k < 4; k++) begin : g_lane
    iq_wr_lane #(.AW(AW), .LANE(k)) u_lane (
      .tail     (tail),
      .push_acc (push_acc),
      .we       (we[k]),
      .idx      (widx[k])
    );
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (!rst && !flush && we[k]) mem[widx[k]] <= issue_queue_element[k];
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + pop_acc[AW-1:0];
      tail  <= tail + push_acc[AW-1:0];
      count <= count + push_acc - pop_acc;
    end
  end

`ifdef IQ_PERF_COUNTER_EN
  // Not cleared by flush: measures decode stalls over the whole run.
  always_ff @(posedge clk) begin
    if (rst)
      iq_full_cycles <= '0;
    else if (count == DEPTH_W && issue_queue_push_number != 3'd0 && iq_full_cycles != '1)
      iq_full_cycles <= iq_full_cycles + 32'd1;
  end
`endif
endmodule

// File: tb/tb_issue_queue.sv
// Scoreboard bench for issue_queue: queue-based reference model, directed corner cases then random traffic.
module tb_issue_queue;
  import issue_queue_pkg::*;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ISSUE_QUEUE_ELEMENT [3:0] elem = '0;
  logic [2:0] push_n = '0;
  logic [2:0] size_left;
  logic       flush = 1'b0;
  ISSUE_QUEUE_ELEMENT [1:0] head_el;
  logic [1:0] head_valid;
  logic [1:0] pop_n = '0;
  logic       ovf, unf;
`ifdef IQ_PERF_COUNTER_EN
  logic [31:0] full_cycles;
  longint      exp_full = 0;
`endif

  always #5 clk = ~clk;

  issue_queue #(.DEPTH(DEPTH)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .issue_queue_element     (elem),
    .issue_queue_push_number (push_n),
    .iq_size_left            (size_left),
    .flush                   (flush),
    .head_element            (head_el),
    .head_valid              (head_valid),
    .issue_pop_number        (pop_n),
    .push_overflow           (ovf),
    .pop_underflow           (unf)
`ifdef IQ_PERF_COUNTER_EN
    ,
    .iq_full_cycles          (full_cycles)
`endif
  );

  int n_chk = 0, n_fail = 0;
  ISSUE_QUEUE_ELEMENT sb_q[$];
  int cnt = 0;      // model occupancy
  int vis = 0;      // entries visible on the head this cycle
  int exp_pop = 0;  // pops the model accepts this cycle

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return a < b ? a : b;
  endfunction

  task automatic drive(input int pn, input int pp, input bit fl, input bit rs);
    int req, acc_push, acc_pop;
    @(negedge clk);
    for (int k = 0; k < 4; k++) elem[k] = ISSUE_QUEUE_ELEMENT'($urandom());
    push_n = 3'(pn); pop_n = 2'(pp); flush = fl; rst = rs;
    #1;
    req = imin(pn, 4);
    chk("push_overflow", ovf, (!rs && !fl && req > DEPTH - cnt) ? 1 : 0);
    chk("pop_underflow", unf, (!rs && !fl && pp > cnt) ? 1 : 0);
    if (!rs) begin
      chk("iq_size_left", size_left, imin(DEPTH - cnt, 4));
      chk("head_valid", head_valid, {cnt >= 2, cnt >= 1});
    end
`ifdef IQ_PERF_COUNTER_EN
    if (!rs && cnt == DEPTH && pn != 0 && exp_full < 64'hFFFF_FFFF) exp_full++;
    if (rs) exp_full = 0;
`endif
    if (rs || fl) begin
      sb_q.delete();
      cnt = 0; vis = 0; exp_pop = 0;
    end else begin
      acc_push = imin(req, DEPTH - cnt);
      acc_pop  = imin(pp, cnt);
      vis = imin(cnt, 2);
      exp_pop = acc_pop;
      for (int k = 0; k < acc_push; k++) sb_q.push_back(elem[k]);
      cnt = cnt + acc_push - acc_pop;
    end
  endtask

  // Monitor: compares visible head slots against the scoreboard front, then retires popped entries.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && !flush) begin
        for (int k = 0; k < vis; k++) begin
          if (sb_q.size() > k) chk("head_element", head_el[k], sb_q[k]);
          else chk("scoreboard_depth", sb_q.size(), k + 1);
        end
        for (int k = 0; k < exp_pop; k++)
          if (sb_q.size() > 0) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    drive(4, 0, 0, 0);          // A..D
    drive(0, 0, 0, 0);          // head {A,B}, free 4
    drive(4, 0, 0, 0);          // fill to 8
    drive(3, 0, 0, 0);          // full: overflow
    drive(0, 1, 0, 0);
    drive(4, 2, 0, 0);          // count 7: 1 accepted, 3 dropped
    repeat (6) drive(0, 2, 0, 0);
    repeat (20) drive(3, 2, 0, 0);
    drive(0, 0, 1, 0);
    drive(4, 0, 0, 0);
    drive(1, 0, 0, 0);          // count 5
    drive(4, 2, 1, 0);          // flush dominates
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(0, 2, 0, 0);          // underflow
    drive(7, 0, 0, 0);          // 5..7 clamp to 4
    drive(5, 0, 0, 0);
    repeat (10) drive(4, 0, 0, 0);
    drive(6, 2, 1, 0);          // flush while full
    repeat (400)
      drive($urandom_range(0, 7), $urandom_range(0, 2),
            $urandom_range(0, 24) == 0, $urandom_range(0, 59) == 0);
    repeat (6) drive(0, 2, 0, 0);
    drive(0, 0, 0, 0);
    chk("final_empty", head_valid, 0);
`ifdef IQ_PERF_COUNTER_EN
    chk("iq_full_cycles", full_cycles, exp_full);
`endif
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
